// File: rtl/dcache_wr_buffer_pkg.sv
// Shared types for the dcache posted-write buffer: queued write entry and
// the access-type encoding common to the dcache and bridge ports.
package dcache_pkg;

  localparam logic [2:0] AXI_TYPE_BYTE = 3'b000;
  localparam logic [2:0] AXI_TYPE_HALF = 3'b001;
  localparam logic [2:0] AXI_TYPE_WORD = 3'b010;
  localparam logic [2:0] AXI_TYPE_LINE = 3'b100;

  typedef struct packed {
    logic [2:0]   wtype;
    logic [31:0]  addr;
    logic [15:0]  wstrb;
    logic [127:0] data;
  } wb_entry_t;

endpackage

// File: rtl/dcache_wr_buffer_if.sv
// SRAM-like read/write memory port; the same shape serves the dcache side
// (buffer is slave) and the AXI-bridge side (buffer is master).
interface dcache_wr_buffer_if;
  logic         rd_req;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic         ret_last;
  logic [127:0] ret_data;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [15:0]  wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy;

  modport master (
    output rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
    input  rd_rdy, ret_valid, ret_last, ret_data, wr_rdy
  );

  modport slave (
    input  rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
    output rd_rdy, ret_valid, ret_last, ret_data, wr_rdy
  );
endinterface

// File: rtl/dcache_wr_buffer_fifo.sv
// Generic synchronous circular FIFO of write-buffer entries with a
// registered occupancy count; head reads as all-zero while empty.
module wb_fifo
  import dcache_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  wb_entry_t                entry_i,
  input  logic                     pop_i,
  output wb_entry_t                head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_entry_t          mem_q [DEPTH];
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == CNT_W'(0));
  assign count_o = count_q;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) begin
      wptr_d = wptr_q + PTR_W'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (do_pop) begin
      rptr_d = rptr_q + PTR_W'(1);
    end else begin
      rptr_d = rptr_q;
    end
    // Simultaneous push and pop leaves occupancy unchanged.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= PTR_W'(0);
      rptr_q  <= PTR_W'(0);
      count_q <= CNT_W'(0);
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= entry_i;
    end
  end

  always_comb begin
    head_o = wb_entry_t'(0);
    if (empty_o) begin
      head_o = wb_entry_t'(0);
    end else begin
      head_o = mem_q[rptr_q];
    end
  end

endmodule

// File: rtl/dcache_wr_buffer.sv
// Posted-write buffer and in-order read sequencer between the dcache and the
// AXI bridge; reads are admitted only once every buffered write has drained.
module dcache_wr_buffer
  import dcache_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  dcache_wr_buffer_if.slave    dc_io,
  dcache_wr_buffer_if.master   bus_io,
  output logic                 wb_empty_o
);

  typedef enum logic [1:0] {
    R_IDLE = 2'b00,
    R_REQ  = 2'b01,
    R_WAIT = 2'b10
  } rstate_e;

  rstate_e                 rstate_q;
  logic [31:0]             rd_addr_q;
  logic [2:0]              rd_type_q;

  wb_entry_t               push_entry;
  wb_entry_t               head;
  logic                    fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    wr_push, wr_pop;

  assign push_entry = '{wtype: dc_io.wr_type, addr: dc_io.wr_addr,
                        wstrb: dc_io.wr_wstrb, data: dc_io.wr_data};
  assign wr_push    = dc_io.wr_req & ~fifo_full;
  assign wr_pop     = ~fifo_empty & bus_io.wr_rdy;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (wr_push),
    .entry_i (push_entry),
    .pop_i   (wr_pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Ready signals come only from registered state to avoid a loop through the dcache.
  assign dc_io.wr_rdy   = ~fifo_full;
  assign dc_io.rd_rdy   = (rstate_q == R_IDLE) & fifo_empty;
  assign wb_empty_o     = (fifo_count == '0);

  assign bus_io.wr_req   = ~fifo_empty;
  assign bus_io.wr_type  = head.wtype;
  assign bus_io.wr_addr  = head.addr;
  assign bus_io.wr_wstrb = head.wstrb;
  assign bus_io.wr_data  = head.data;

  assign bus_io.rd_req  = (rstate_q == R_REQ);
  assign bus_io.rd_addr = (rstate_q == R_REQ) ? rd_addr_q : 32'h0000_0000;
  assign bus_io.rd_type = (rstate_q == R_REQ) ? rd_type_q : 3'b000;

  always_ff @(posedge clk) begin
    if (rst) begin
      rstate_q  <= R_IDLE;
      rd_addr_q <= 32'h0000_0000;
      rd_type_q <= 3'b000;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          if (dc_io.rd_req && dc_io.rd_rdy) begin
            rd_addr_q <= dc_io.rd_addr;
            rd_type_q <= dc_io.rd_type;
            rstate_q  <= R_REQ;
          end
        end
        R_REQ: begin
          if (bus_io.rd_rdy) begin
            rstate_q <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (bus_io.ret_valid && bus_io.ret_last) begin
            rstate_q <= R_IDLE;
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  always_comb begin
    dc_io.ret_valid = 1'b0;
    dc_io.ret_last  = 1'b0;
    dc_io.ret_data  = 128'h0;
    if (rstate_q == R_WAIT) begin
      dc_io.ret_valid = bus_io.ret_valid;
      dc_io.ret_last  = bus_io.ret_last;
      dc_io.ret_data  = bus_io.ret_data;
    end else begin
      dc_io.ret_valid = 1'b0;
      dc_io.ret_last  = 1'b0;
      dc_io.ret_data  = 128'h0;
    end
  end

endmodule

// File: tb/tb_dcache_wr_buffer.sv
// Directed bench for dcache_wr_buffer: write posting/draining, full handling,
// read-after-write ordering, read return path and mid-operation reset.
module tb_dcache_wr_buffer;
  import dcache_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic wb_empty;
  int   n_checks = 0;
  int   n_fail   = 0;

  dcache_wr_buffer_if dc_if();
  dcache_wr_buffer_if bus_if();

  dcache_wr_buffer #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .dc_io      (dc_if.slave),
    .bus_io     (bus_if.master),
    .wb_empty_o (wb_empty)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    dc_if.rd_req = 1'b0; dc_if.rd_type = 3'b000; dc_if.rd_addr = 32'h0;
    dc_if.wr_req = 1'b0; dc_if.wr_type = 3'b000; dc_if.wr_addr = 32'h0;
    dc_if.wr_wstrb = 16'h0; dc_if.wr_data = 128'h0;
    bus_if.rd_rdy = 1'b0; bus_if.ret_valid = 1'b0; bus_if.ret_last = 1'b0;
    bus_if.ret_data = 128'h0; bus_if.wr_rdy = 1'b0;
  endtask

  task automatic set_wr(input logic [31:0] a);
    dc_if.wr_req = 1'b1; dc_if.wr_type = AXI_TYPE_WORD; dc_if.wr_addr = a;
    dc_if.wr_wstrb = 16'h000F; dc_if.wr_data = {96'h0, a};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    step(); step();
    rst = 1'b0;
    #1;
    n_checks++; if (bus_if.wr_req !== 1'b0) begin n_fail++; $display("FAIL rst_bus_wr_req got %b exp 0", bus_if.wr_req); end
    n_checks++; if (bus_if.rd_req !== 1'b0) begin n_fail++; $display("FAIL rst_bus_rd_req got %b exp 0", bus_if.rd_req); end
    n_checks++; if (bus_if.wr_addr !== 32'h0) begin n_fail++; $display("FAIL rst_bus_wr_addr got %h exp 0", bus_if.wr_addr); end
    n_checks++; if (dc_if.wr_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_dc_wr_rdy got %b exp 1", dc_if.wr_rdy); end
    n_checks++; if (dc_if.rd_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_dc_rd_rdy got %b exp 1", dc_if.rd_rdy); end
    n_checks++; if (dc_if.ret_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dc_ret_valid got %b exp 0", dc_if.ret_valid); end
    n_checks++; if (wb_empty !== 1'b1) begin n_fail++; $display("FAIL rst_wb_empty got %b exp 1", wb_empty); end
  endtask

  task automatic test_single_write();
    bus_if.wr_rdy = 1'b1;
    dc_if.wr_req = 1'b1; dc_if.wr_type = AXI_TYPE_WORD; dc_if.wr_addr = 32'h1C00_0004;
    dc_if.wr_wstrb = 16'h00F0; dc_if.wr_data = 128'h0000_0000_0000_0000_DEAD_BEEF_0000_0000;
    #1;
    n_checks++; if (bus_if.wr_req !== 1'b0) begin n_fail++; $display("FAIL t1_no_early_req got %b exp 0", bus_if.wr_req); end
    step();
    dc_if.wr_req = 1'b0;
    #1;
    n_checks++; if (bus_if.wr_req !== 1'b1) begin n_fail++; $display("FAIL t1_req got %b exp 1", bus_if.wr_req); end
    n_checks++; if (bus_if.wr_addr !== 32'h1C00_0004) begin n_fail++; $display("FAIL t1_addr got %h exp 1c000004", bus_if.wr_addr); end
    n_checks++; if (bus_if.wr_wstrb !== 16'h00F0) begin n_fail++; $display("FAIL t1_wstrb got %h exp 00f0", bus_if.wr_wstrb); end
    n_checks++; if (bus_if.wr_data !== 128'h0000_0000_0000_0000_DEAD_BEEF_0000_0000) begin n_fail++; $display("FAIL t1_data got %h", bus_if.wr_data); end
    n_checks++; if (bus_if.wr_type !== 3'b010) begin n_fail++; $display("FAIL t1_type got %b exp 010", bus_if.wr_type); end
    n_checks++; if (wb_empty !== 1'b0) begin n_fail++; $display("FAIL t1_not_empty got %b exp 0", wb_empty); end
    step();
    n_checks++; if (wb_empty !== 1'b1) begin n_fail++; $display("FAIL t1_empty_after got %b exp 1", wb_empty); end
    n_checks++; if (bus_if.wr_req !== 1'b0) begin n_fail++; $display("FAIL t1_req_after got %b exp 0", bus_if.wr_req); end
    n_checks++; if (bus_if.wr_addr !== 32'h0) begin n_fail++; $display("FAIL t1_addr_zero got %h exp 0", bus_if.wr_addr); end
    bus_if.wr_rdy = 1'b0;
  endtask

  task automatic test_full();
    bus_if.wr_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_wr(32'h100 + 32'(i * 4));
      step();
    end
    set_wr(32'h200);
    #1;
    n_checks++; if (dc_if.wr_rdy !== 1'b0) begin n_fail++; $display("FAIL t2_full_rdy got %b exp 0", dc_if.wr_rdy); end
    step();
    dc_if.wr_req = 1'b0;
    #1;
    n_checks++; if (dc_if.wr_rdy !== 1'b0) begin n_fail++; $display("FAIL t2_still_full got %b exp 0", dc_if.wr_rdy); end
    bus_if.wr_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (bus_if.wr_addr !== 32'h100 + 32'(i * 4)) begin n_fail++; $display("FAIL t2_order[%0d] got %h exp %h", i, bus_if.wr_addr, 32'h100 + 32'(i * 4)); end
      n_checks++; if (bus_if.wr_data[31:0] !== 32'h100 + 32'(i * 4)) begin n_fail++; $display("FAIL t2_data[%0d] got %h", i, bus_if.wr_data[31:0]); end
      if (i == 1) begin
        n_checks++; if (dc_if.wr_rdy !== 1'b1) begin n_fail++; $display("FAIL t2_rdy_after_pop got %b exp 1", dc_if.wr_rdy); end
      end
      step();
    end
    n_checks++; if (wb_empty !== 1'b1) begin n_fail++; $display("FAIL t2_drained got %b exp 1", wb_empty); end
    n_checks++; if (bus_if.wr_req !== 1'b0) begin n_fail++; $display("FAIL t2_no_fifth got %b exp 0", bus_if.wr_req); end
    bus_if.wr_rdy = 1'b0;
  endtask

  task automatic test_push_pop();
    logic [31:0] exp_a [4];
    exp_a[0] = 32'h304; exp_a[1] = 32'h308; exp_a[2] = 32'h30C; exp_a[3] = 32'h310;
    bus_if.wr_rdy = 1'b0;
    set_wr(32'h300); step();
    set_wr(32'h304); step();
    set_wr(32'h308); bus_if.wr_rdy = 1'b1;
    #1;
    n_checks++; if (bus_if.wr_addr !== 32'h300) begin n_fail++; $display("FAIL t3_head_a got %h exp 300", bus_if.wr_addr); end
    step();
    dc_if.wr_req = 1'b0; bus_if.wr_rdy = 1'b0;
    #1;
    n_checks++; if (bus_if.wr_addr !== 32'h304) begin n_fail++; $display("FAIL t3_head_b got %h exp 304", bus_if.wr_addr); end
    n_checks++; if (dc_if.wr_rdy !== 1'b1) begin n_fail++; $display("FAIL t3_cnt2_rdy got %b exp 1", dc_if.wr_rdy); end
    set_wr(32'h30C); step();
    set_wr(32'h310); step();
    dc_if.wr_req = 1'b0;
    #1;
    n_checks++; if (dc_if.wr_rdy !== 1'b0) begin n_fail++; $display("FAIL t3_cnt4_full got %b exp 0", dc_if.wr_rdy); end
    bus_if.wr_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (bus_if.wr_addr !== exp_a[i]) begin n_fail++; $display("FAIL t3_order[%0d] got %h exp %h", i, bus_if.wr_addr, exp_a[i]); end
      step();
    end
    n_checks++; if (wb_empty !== 1'b1) begin n_fail++; $display("FAIL t3_drained got %b exp 1", wb_empty); end
    bus_if.wr_rdy = 1'b0;
  endtask

  task automatic test_raw_order();
    bus_if.wr_rdy = 1'b0;
    set_wr(32'h400); step();
    set_wr(32'h404); step();
    dc_if.wr_req = 1'b0;
    dc_if.rd_req = 1'b1; dc_if.rd_addr = 32'h1C00_0008; dc_if.rd_type = AXI_TYPE_WORD;
    #1;
    n_checks++; if (dc_if.rd_rdy !== 1'b0) begin n_fail++; $display("FAIL t4_rd_blocked got %b exp 0", dc_if.rd_rdy); end
    step();
    n_checks++; if (bus_if.rd_req !== 1'b0) begin n_fail++; $display("FAIL t4_no_bus_rd got %b exp 0", bus_if.rd_req); end
    bus_if.wr_rdy = 1'b1;
    step();
    n_checks++; if (dc_if.rd_rdy !== 1'b0) begin n_fail++; $display("FAIL t4_rd_blocked_cnt1 got %b exp 0", dc_if.rd_rdy); end
    step();
    n_checks++; if (dc_if.rd_rdy !== 1'b1) begin n_fail++; $display("FAIL t4_rd_rdy_empty got %b exp 1", dc_if.rd_rdy); end
    n_checks++; if (bus_if.rd_req !== 1'b0) begin n_fail++; $display("FAIL t4_bus_rd_not_yet got %b exp 0", bus_if.rd_req); end
    step();
    dc_if.rd_req = 1'b0; bus_if.wr_rdy = 1'b0;
    #1;
    n_checks++; if (bus_if.rd_req !== 1'b1) begin n_fail++; $display("FAIL t4_bus_rd_req got %b exp 1", bus_if.rd_req); end
    n_checks++; if (bus_if.rd_addr !== 32'h1C00_0008) begin n_fail++; $display("FAIL t4_bus_rd_addr got %h exp 1c000008", bus_if.rd_addr); end
    n_checks++; if (bus_if.rd_type !== 3'b010) begin n_fail++; $display("FAIL t4_bus_rd_type got %b exp 010", bus_if.rd_type); end
    bus_if.rd_rdy = 1'b1; step();
    bus_if.rd_rdy = 1'b0;
    bus_if.ret_valid = 1'b1; bus_if.ret_last = 1'b1; bus_if.ret_data = 128'h55;
    #1;
    n_checks++; if (dc_if.ret_valid !== 1'b1) begin n_fail++; $display("FAIL t4_ret_valid got %b exp 1", dc_if.ret_valid); end
    step();
    bus_if.ret_valid = 1'b0; bus_if.ret_last = 1'b0;
    #1;
    n_checks++; if (dc_if.rd_rdy !== 1'b1) begin n_fail++; $display("FAIL t4_rd_done got %b exp 1", dc_if.rd_rdy); end
  endtask

  task automatic test_read_return();
    dc_if.rd_req = 1'b1; dc_if.rd_addr = 32'h1C00_0010; dc_if.rd_type = AXI_TYPE_LINE;
    step();
    dc_if.rd_req = 1'b0;
    #1;
    n_checks++; if (dc_if.rd_rdy !== 1'b0) begin n_fail++; $display("FAIL t5_rd_busy got %b exp 0", dc_if.rd_rdy); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (bus_if.rd_req !== 1'b1) begin n_fail++; $display("FAIL t5_hold_req[%0d] got %b exp 1", i, bus_if.rd_req); end
      step();
    end
    n_checks++; if (bus_if.rd_type !== 3'b100) begin n_fail++; $display("FAIL t5_type got %b exp 100", bus_if.rd_type); end
    bus_if.rd_rdy = 1'b1; step();
    bus_if.rd_rdy = 1'b0;
    #1;
    n_checks++; if (bus_if.rd_req !== 1'b0) begin n_fail++; $display("FAIL t5_req_drop got %b exp 0", bus_if.rd_req); end
    bus_if.ret_valid = 1'b1; bus_if.ret_last = 1'b0; bus_if.ret_data = 128'h1111;
    #1;
    n_checks++; if (dc_if.ret_data !== 128'h1111 || dc_if.ret_last !== 1'b0) begin n_fail++; $display("FAIL t5_beat0 got %h/%b exp 1111/0", dc_if.ret_data, dc_if.ret_last); end
    step();
    bus_if.ret_last = 1'b1; bus_if.ret_data = 128'h1234_5678_9ABC_DEF0_0000_0000_0000_CAFE;
    #1;
    n_checks++; if (dc_if.ret_valid !== 1'b1) begin n_fail++; $display("FAIL t5_valid got %b exp 1", dc_if.ret_valid); end
    n_checks++; if (dc_if.ret_data !== 128'h1234_5678_9ABC_DEF0_0000_0000_0000_CAFE) begin n_fail++; $display("FAIL t5_data got %h", dc_if.ret_data); end
    n_checks++; if (dc_if.ret_last !== 1'b1) begin n_fail++; $display("FAIL t5_last got %b exp 1", dc_if.ret_last); end
    n_checks++; if (dc_if.rd_rdy !== 1'b0) begin n_fail++; $display("FAIL t5_rdy_during got %b exp 0", dc_if.rd_rdy); end
    step();
    n_checks++; if (dc_if.rd_rdy !== 1'b1) begin n_fail++; $display("FAIL t5_rdy_next got %b exp 1", dc_if.rd_rdy); end
    n_checks++; if (dc_if.ret_valid !== 1'b0) begin n_fail++; $display("FAIL t5_ret_gated got %b exp 0", dc_if.ret_valid); end
    n_checks++; if (dc_if.ret_data !== 128'h0) begin n_fail++; $display("FAIL t5_data_gated got %h exp 0", dc_if.ret_data); end
    bus_if.ret_valid = 1'b0; bus_if.ret_last = 1'b0; bus_if.ret_data = 128'h0;
  endtask

  task automatic test_reset_midop();
    dc_if.rd_req = 1'b1; dc_if.rd_addr = 32'h1C00_0020; dc_if.rd_type = AXI_TYPE_WORD;
    step();
    dc_if.rd_req = 1'b0; bus_if.rd_rdy = 1'b1;
    step();
    bus_if.rd_rdy = 1'b0; bus_if.wr_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_wr(32'h500 + 32'(i * 4));
      step();
    end
    dc_if.wr_req = 1'b0;
    #1;
    n_checks++; if (bus_if.wr_req !== 1'b1) begin n_fail++; $display("FAIL t6_pre_wr_req got %b exp 1", bus_if.wr_req); end
    bus_if.wr_rdy = 1'b1; bus_if.ret_valid = 1'b1; bus_if.ret_last = 1'b0; bus_if.ret_data = 128'hABCD;
    #1;
    n_checks++; if (dc_if.ret_valid !== 1'b1) begin n_fail++; $display("FAIL t6_pre_wait got %b exp 1", dc_if.ret_valid); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    n_checks++; if (bus_if.wr_req !== 1'b0) begin n_fail++; $display("FAIL t6_wr_req got %b exp 0", bus_if.wr_req); end
    n_checks++; if (wb_empty !== 1'b1) begin n_fail++; $display("FAIL t6_empty got %b exp 1", wb_empty); end
    n_checks++; if (dc_if.wr_rdy !== 1'b1) begin n_fail++; $display("FAIL t6_wr_rdy got %b exp 1", dc_if.wr_rdy); end
    n_checks++; if (dc_if.rd_rdy !== 1'b1) begin n_fail++; $display("FAIL t6_rd_rdy got %b exp 1", dc_if.rd_rdy); end
    n_checks++; if (bus_if.rd_req !== 1'b0) begin n_fail++; $display("FAIL t6_rd_req got %b exp 0", bus_if.rd_req); end
    n_checks++; if (dc_if.ret_valid !== 1'b0) begin n_fail++; $display("FAIL t6_ret_valid got %b exp 0", dc_if.ret_valid); end
    step();
    n_checks++; if (bus_if.wr_req !== 1'b0) begin n_fail++; $display("FAIL t6_wr_req_later got %b exp 0", bus_if.wr_req); end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_full();
    test_push_pop();
    test_raw_order();
    test_read_return();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
